hit_resolver: RTL and testbench

//  Combat arbiter for both player FSMs. Each cycle it checks each player's active hitbox against the opponent's main hurtbox.
//  It also decides hit vs block and owns the health and block meters.

---
 rtl/hit_resolver_pkg.sv | 47 ++++
 rtl/hit_resolver_if.sv | 43 ++++
 rtl/hit_resolver_box_overlap.sv | 13 +
 rtl/hit_resolver.sv | 157 +++++++++++++++
 tb/tb_hit_resolver.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hit_resolver_pkg.sv
// Shared combat definitions: player state encodings, hit flag encodings and meter constants.
// Imported by the resolver and by the player FSMs.
package hit_resolver_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned METER_W = 3;
    localparam int unsigned FLAG_W  = 2;
    localparam int unsigned GS_W    = 3;
    localparam int unsigned REGEN_W = 8;

    localparam int unsigned REGEN_TICKS = 60;

    localparam logic [METER_W-1:0] MAX_HEALTH = 3'd5;
    localparam logic [METER_W-1:0] MAX_BLOCK  = 3'd3;
    localparam logic [METER_W-1:0] DMG_BASIC  = 3'd1;
    localparam logic [METER_W-1:0] DMG_DIR    = 3'd2;
    localparam logic [GS_W-1:0]    GS_FIGHT   = 3'd2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE            = 4'd0,
        S_MOVEFORWARDS    = 4'd1,
        S_MOVEBACKWARDS   = 4'd2,
        S_B_ATTACK_START  = 4'd3,
        S_B_ATTACK_END    = 4'd4,
        S_D_ATTACK_START  = 4'd5,
        S_D_ATTACK_ACTIVE = 4'd6,
        S_D_ATTACK_END    = 4'd7,
        S_RECOVERY        = 4'd8,
        S_HITSTUN         = 4'd9,
        S_BLOCKSTUN       = 4'd10
    } player_state_e;

    typedef enum logic [FLAG_W-1:0] {
        HIT_NONE  = 2'b00,
        HIT_BASIC = 2'b01,
        HIT_DIR   = 2'b10
    } hit_flag_e;

    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] y2;
    } box_t;

endpackage

// File: rtl/hit_resolver_if.sv
// Player/HUD-facing signal bundle of the hit resolver.
// master = players/gamestate side, slave = resolver.
interface hit_resolver_if;
    import hit_resolver_pkg::*;

    logic [GS_W-1:0]    gamestate;
    logic [STATE_W-1:0] p1_state, p2_state;
    logic [COORD_W-1:0] p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2;
    logic [COORD_W-1:0] p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2;
    logic [COORD_W-1:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [COORD_W-1:0] p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2;
    logic [COORD_W-1:0] p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2;
    logic [COORD_W-1:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
    logic [FLAG_W-1:0]  p1_hitFlag, p2_hitFlag;
    logic [METER_W-1:0] p1_health, p2_health;
    logic [METER_W-1:0] p1_block, p2_block;
    logic [1:0]         ko;

    modport master (
        output gamestate, p1_state, p2_state,
        output p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2,
        output p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2,
        output p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
        output p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2,
        output p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2,
        output p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
        input  p1_hitFlag, p2_hitFlag, p1_health, p2_health,
        input  p1_block, p2_block, ko
    );

    modport slave (
        input  gamestate, p1_state, p2_state,
        input  p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2,
        input  p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2,
        input  p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
        input  p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2,
        input  p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2,
        input  p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
        output p1_hitFlag, p2_hitFlag, p1_health, p2_health,
        output p1_block, p2_block, ko
    );

endinterface

// File: rtl/hit_resolver_box_overlap.sv
// Closed-interval rectangle intersection test on unsigned coordinates.
module hit_resolver_box_overlap
    import hit_resolver_pkg::*;
(
    input  box_t a_i,
    input  box_t b_i,
    output logic overlap_c_o
);

    assign overlap_c_o = (a_i.x1 <= b_i.x2) && (b_i.x1 <= a_i.x2) &&
                         (a_i.y1 <= b_i.y2) && (b_i.y1 <= a_i.y2);

endmodule

// File: rtl/hit_resolver.sv
// Combat arbiter: detects hitbox/hurtbox contact between the two players, flags the defender,
// and owns the health, block and KO state fed back to the players and HUD.
module hit_resolver
    import hit_resolver_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    hit_resolver_if.slave bus
);

    box_t [1:0]               basic_box, dir_box, hurt_box;
    logic [1:0][STATE_W-1:0]  pstate;
    logic [1:0]               basic_ov, dir_ov;

    // All per-player arrays are indexed by player (0 = p1, 1 = p2); hit state by defender.
    logic [1:0][FLAG_W-1:0]   flag_q, flag_d;
    logic [1:0][METER_W-1:0]  health_q, health_d;
    logic [1:0][METER_W-1:0]  block_q, block_d;
    logic [1:0][METER_W-1:0]  pend_dmg_q, pend_dmg_d;
    logic [1:0]               ko_q, ko_d;
    logic [1:0]               consumed_q, consumed_d;
    logic [1:0]               pend_q, pend_d;
    logic [1:0]               pend_blk_q, pend_blk_d;
    logic [REGEN_W-1:0]       regen_cnt_q, regen_cnt_d;

    logic [1:0][FLAG_W-1:0]   kind_c;
    logic [1:0]               hit_c;
    logic [1:0]               swing_c;
    logic                     fight_c;
    logic                     live_c;
    logic                     regen_wrap_c;

    assign pstate[0]    = bus.p1_state;
    assign pstate[1]    = bus.p2_state;
    assign basic_box[0] = {bus.p1_basic_x1, bus.p1_basic_x2, bus.p1_basic_y1, bus.p1_basic_y2};
    assign dir_box[0]   = {bus.p1_dir_x1, bus.p1_dir_x2, bus.p1_dir_y1, bus.p1_dir_y2};
    assign hurt_box[0]  = {bus.p1_hurt_x1, bus.p1_hurt_x2, bus.p1_hurt_y1, bus.p1_hurt_y2};
    assign basic_box[1] = {bus.p2_basic_x1, bus.p2_basic_x2, bus.p2_basic_y1, bus.p2_basic_y2};
    assign dir_box[1]   = {bus.p2_dir_x1, bus.p2_dir_x2, bus.p2_dir_y1, bus.p2_dir_y2};
    assign hurt_box[1]  = {bus.p2_hurt_x1, bus.p2_hurt_x2, bus.p2_hurt_y1, bus.p2_hurt_y2};

    // Attacker boxes tested against the defender's hurtbox, one pair per defender.
    for (genvar d = 0; d < 2; d++) begin : g_def
        hit_resolver_box_overlap u_basic (
            .a_i         (basic_box[1'(1 - d)]),
            .b_i         (hurt_box[1'(d)]),
            .overlap_c_o (basic_ov[d])
        );
        hit_resolver_box_overlap u_dir (
            .a_i         (dir_box[1'(1 - d)]),
            .b_i         (hurt_box[1'(d)]),
            .overlap_c_o (dir_ov[d])
        );
    end

    always_comb begin
        flag_d       = '0;
        health_d     = health_q;
        block_d      = block_q;
        pend_dmg_d   = pend_dmg_q;
        ko_d         = ko_q;
        consumed_d   = consumed_q;
        pend_d       = '0;
        pend_blk_d   = '0;
        regen_cnt_d  = regen_cnt_q;
        kind_c       = '0;
        hit_c        = '0;
        swing_c      = '0;
        fight_c      = (bus.gamestate == GS_FIGHT);
        live_c       = ~(|ko_q);
        regen_wrap_c = (regen_cnt_q == REGEN_W'(REGEN_TICKS - 1));

        if (live_c) begin
            regen_cnt_d = regen_wrap_c ? '0 : regen_cnt_q + REGEN_W'(1);
        end

        for (int d = 0; d < 2; d++) begin
            swing_c[1'(d)] = (pstate[1'(1 - d)] == S_B_ATTACK_END) ||
                             (pstate[1'(1 - d)] == S_D_ATTACK_END);
            if ((pstate[1'(1 - d)] == S_B_ATTACK_END) && basic_ov[1'(d)]) begin
                kind_c[1'(d)] = HIT_BASIC;
            end else if ((pstate[1'(1 - d)] == S_D_ATTACK_END) && dir_ov[1'(d)]) begin
                kind_c[1'(d)] = HIT_DIR;
            end

            hit_c[1'(d)] = (kind_c[1'(d)] != HIT_NONE) && !consumed_q[1'(d)] && live_c &&
                           (pstate[1'(d)] != S_HITSTUN) && (pstate[1'(d)] != S_BLOCKSTUN);

            flag_d[1'(d)]     = hit_c[1'(d)] ? kind_c[1'(d)] : HIT_NONE;
            pend_d[1'(d)]     = hit_c[1'(d)];
            pend_blk_d[1'(d)] = (pstate[1'(d)] == S_MOVEBACKWARDS) && (block_q[1'(d)] != '0);
            pend_dmg_d[1'(d)] = (kind_c[1'(d)] == HIT_DIR) ? DMG_DIR : DMG_BASIC;
            consumed_d[1'(d)] = swing_c[1'(d)] && (consumed_q[1'(d)] || hit_c[1'(d)]);

            // Second-stage meter update; a block decrement pre-empts regen on the same edge.
            if (pend_q[1'(d)] && pend_blk_q[1'(d)]) begin
                if (block_q[1'(d)] != '0) begin
                    block_d[1'(d)] = block_q[1'(d)] - METER_W'(1);
                end
            end else if (regen_wrap_c && live_c && (block_q[1'(d)] < MAX_BLOCK)) begin
                block_d[1'(d)] = block_q[1'(d)] + METER_W'(1);
            end

            if (pend_q[1'(d)] && !pend_blk_q[1'(d)]) begin
                health_d[1'(d)] = (health_q[1'(d)] > pend_dmg_q[1'(d)]) ?
                                  health_q[1'(d)] - pend_dmg_q[1'(d)] : '0;
            end

            ko_d[1'(d)] = ko_q[1'(d)] || (health_d[1'(d)] == '0);
        end

        if (!fight_c) begin
            flag_d      = '0;
            health_d    = {2{MAX_HEALTH}};
            block_d     = {2{MAX_BLOCK}};
            pend_dmg_d  = '0;
            ko_d        = '0;
            consumed_d  = '0;
            pend_d      = '0;
            pend_blk_d  = '0;
            regen_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            flag_q      <= '0;
            health_q    <= {2{MAX_HEALTH}};
            block_q     <= {2{MAX_BLOCK}};
            pend_dmg_q  <= '0;
            ko_q        <= '0;
            consumed_q  <= '0;
            pend_q      <= '0;
            pend_blk_q  <= '0;
            regen_cnt_q <= '0;
        end else begin
            flag_q      <= flag_d;
            health_q    <= health_d;
            block_q     <= block_d;
            pend_dmg_q  <= pend_dmg_d;
            ko_q        <= ko_d;
            consumed_q  <= consumed_d;
            pend_q      <= pend_d;
            pend_blk_q  <= pend_blk_d;
            regen_cnt_q <= regen_cnt_d;
        end
    end

    assign bus.p1_hitFlag = flag_q[0];
    assign bus.p2_hitFlag = flag_q[1];
    assign bus.p1_health  = health_q[0];
    assign bus.p2_health  = health_q[1];
    assign bus.p1_block   = block_q[0];
    assign bus.p2_block   = block_q[1];
    assign bus.ko         = ko_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Bench for hit_resolver: directed combat scenarios plus randomized play checked
// against an event-queue reference model of the combat rules.
module tb_hit_resolver;

    localparam int T_MAX_H = 5;
    localparam int T_MAX_B = 3;
    localparam int T_REGEN = 60;

    typedef struct {
        int def;
        int due;
        bit blk;
        int dmg;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    hit_resolver_if bus();

    hit_resolver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int  m_health [2];
    int  m_block  [2];
    int  m_flag   [2];
    bit  m_ko     [2];
    bit  m_used   [2];   // indexed by attacker
    int  m_regen;
    int  cyc = 0;
    ev_t evq [$];

    function automatic int pst(int p);
        return (p == 0) ? int'(bus.p1_state) : int'(bus.p2_state);
    endfunction

    // kind: 0 basic, 1 directional, 2 hurt; packed as {x1,x2,y1,y2}
    function automatic logic [39:0] box_of(int p, int kind);
        if (p == 0) begin
            if (kind == 0) return {bus.p1_basic_x1, bus.p1_basic_x2, bus.p1_basic_y1, bus.p1_basic_y2};
            if (kind == 1) return {bus.p1_dir_x1, bus.p1_dir_x2, bus.p1_dir_y1, bus.p1_dir_y2};
            return {bus.p1_hurt_x1, bus.p1_hurt_x2, bus.p1_hurt_y1, bus.p1_hurt_y2};
        end
        if (kind == 0) return {bus.p2_basic_x1, bus.p2_basic_x2, bus.p2_basic_y1, bus.p2_basic_y2};
        if (kind == 1) return {bus.p2_dir_x1, bus.p2_dir_x2, bus.p2_dir_y1, bus.p2_dir_y2};
        return {bus.p2_hurt_x1, bus.p2_hurt_x2, bus.p2_hurt_y1, bus.p2_hurt_y2};
    endfunction

    function automatic bit ovl(logic [39:0] a, logic [39:0] b);
        return (a[39:30] <= b[29:20]) && (b[39:30] <= a[29:20]) &&
               (a[19:10] <= b[9:0])   && (b[19:10] <= a[9:0]);
    endfunction

    task automatic set_box(int p, int kind, int x1, int x2, int y1, int y2);
        logic [9:0] a, b, c, d;
        a = 10'(x1); b = 10'(x2); c = 10'(y1); d = 10'(y2);
        if (p == 0 && kind == 0) begin bus.p1_basic_x1 = a; bus.p1_basic_x2 = b; bus.p1_basic_y1 = c; bus.p1_basic_y2 = d; end
        if (p == 0 && kind == 1) begin bus.p1_dir_x1 = a; bus.p1_dir_x2 = b; bus.p1_dir_y1 = c; bus.p1_dir_y2 = d; end
        if (p == 0 && kind == 2) begin bus.p1_hurt_x1 = a; bus.p1_hurt_x2 = b; bus.p1_hurt_y1 = c; bus.p1_hurt_y2 = d; end
        if (p == 1 && kind == 0) begin bus.p2_basic_x1 = a; bus.p2_basic_x2 = b; bus.p2_basic_y1 = c; bus.p2_basic_y2 = d; end
        if (p == 1 && kind == 1) begin bus.p2_dir_x1 = a; bus.p2_dir_x2 = b; bus.p2_dir_y1 = c; bus.p2_dir_y2 = d; end
        if (p == 1 && kind == 2) begin bus.p2_hurt_x1 = a; bus.p2_hurt_x2 = b; bus.p2_hurt_y1 = c; bus.p2_hurt_y2 = d; end
    endtask

    // Reference model: advances one clock edge using the inputs held during the cycle.
    task automatic model_edge();
        int  typ [2];
        bit  hit [2];
        bit  blk [2];
        bit  dec [2];
        bit  any_ko;
        ev_t keep [$];
        ev_t e;
        cyc++;
        if (rst !== 1'b1 || bus.gamestate != 3'd2) begin
            for (int p = 0; p < 2; p++) begin
                m_health[p] = T_MAX_H; m_block[p] = T_MAX_B;
                m_flag[p] = 0; m_ko[p] = 0; m_used[p] = 0;
            end
            m_regen = 0;
            evq.delete();
            return;
        end
        any_ko = m_ko[0] || m_ko[1];
        for (int d = 0; d < 2; d++) begin
            typ[d] = 0;
            if (pst(1 - d) == 4 && ovl(box_of(1 - d, 0), box_of(d, 2))) typ[d] = 1;
            else if (pst(1 - d) == 7 && ovl(box_of(1 - d, 1), box_of(d, 2))) typ[d] = 2;
            hit[d] = (typ[d] != 0) && !m_used[1 - d] && pst(d) != 9 && pst(d) != 10 && !any_ko;
            blk[d] = (pst(d) == 2) && (m_block[d] > 0);
            dec[d] = 0;
        end
        foreach (evq[i]) begin
            if (evq[i].due == cyc) begin
                if (evq[i].blk) begin
                    dec[evq[i].def] = 1;
                    if (m_block[evq[i].def] > 0) m_block[evq[i].def]--;
                end else begin
                    m_health[evq[i].def] = (m_health[evq[i].def] > evq[i].dmg) ?
                                           m_health[evq[i].def] - evq[i].dmg : 0;
                end
            end else begin
                keep.push_back(evq[i]);
            end
        end
        evq = keep;
        if (!any_ko) begin
            m_regen++;
            if (m_regen == T_REGEN) begin
                m_regen = 0;
                for (int d = 0; d < 2; d++)
                    if (!dec[d] && m_block[d] < T_MAX_B) m_block[d]++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (m_health[d] == 0) m_ko[d] = 1;
            m_flag[d] = hit[d] ? typ[d] : 0;
            if (hit[d]) begin
                e.def = d; e.due = cyc + 1; e.blk = blk[d]; e.dmg = (typ[d] == 2) ? 2 : 1;
                evq.push_back(e);
            end
        end
        for (int a = 0; a < 2; a++)
            m_used[a] = (pst(a) == 4 || pst(a) == 7) && (m_used[a] || hit[1 - a]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // p1 attack boxes reach p2's hurtbox; p2 attack boxes miss p1.
    task automatic default_layout();
        bus.gamestate = 3'd2;
        bus.p1_state  = 4'd0;
        bus.p2_state  = 4'd0;
        set_box(0, 2, 0, 20, 0, 20);
        set_box(1, 2, 200, 220, 0, 20);
        set_box(0, 0, 190, 205, 5, 15);
        set_box(0, 1, 190, 205, 5, 15);
        set_box(1, 0, 500, 510, 5, 15);
        set_box(1, 1, 500, 510, 5, 15);
    endtask

    task automatic do_reset();
        default_layout();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.p1_hitFlag, bus.p2_hitFlag, bus.p1_health, bus.p2_health, bus.p1_block, bus.p2_block, bus.ko}
            !== {2'b00, 2'b00, 3'd5, 3'd5, 3'd3, 3'd3, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_values: got f%b/%b h%0d/%0d b%0d/%0d ko%b want f00/00 h5/5 b3/3 ko00",
                     bus.p1_hitFlag, bus.p2_hitFlag, bus.p1_health, bus.p2_health, bus.p1_block, bus.p2_block, bus.ko);
        end
    endtask

    task automatic test_basic_hit();
        do_reset();
        tick();
        bus.p1_state = 4'd4;
        tick();
        n_checks++;
        if ({bus.p1_hitFlag, bus.p2_hitFlag, bus.p2_health} !== {2'b00, 2'b01, 3'd5}) begin
            n_fail++;
            $display("FAIL basic_flag: got p1f=%b p2f=%b p2h=%0d want 00 01 5", bus.p1_hitFlag, bus.p2_hitFlag, bus.p2_health);
        end
        bus.p1_state = 4'd0;
        tick();
        n_checks++;
        if ({bus.p2_hitFlag, bus.p2_health, bus.p2_block} !== {2'b00, 3'd4, 3'd3}) begin
            n_fail++;
            $display("FAIL basic_damage: got p2f=%b p2h=%0d p2b=%0d want 00 4 3", bus.p2_hitFlag, bus.p2_health, bus.p2_block);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        set_box(0, 0, 180, 199, 20, 30);
        bus.p1_state = 4'd4;
        tick();
        n_checks++;
        if (bus.p2_hitFlag !== 2'b00) begin
            n_fail++;
            $display("FAIL edge_gap: got %b want 00", bus.p2_hitFlag);
        end
        bus.p1_state = 4'd0;
        tick();
        set_box(0, 0, 180, 200, 20, 30);
        bus.p1_state = 4'd4;
        tick();
        n_checks++;
        if (bus.p2_hitFlag !== 2'b01) begin
            n_fail++;
            $display("FAIL edge_touch: got %b want 01", bus.p2_hitFlag);
        end
    endtask

    task automatic test_dir_block();
        do_reset();
        bus.p2_state = 4'd2;
        bus.p1_state = 4'd7;
        tick();
        n_checks++;
        if ({bus.p2_hitFlag, bus.p2_block, bus.p2_health} !== {2'b10, 3'd3, 3'd5}) begin
            n_fail++;
            $display("FAIL dir_flag_premeter: got f=%b b=%0d h=%0d want 10 3 5", bus.p2_hitFlag, bus.p2_block, bus.p2_health);
        end
        bus.p1_state = 4'd0;
        tick();
        n_checks++;
        if ({bus.p2_block, bus.p2_health} !== {3'd2, 3'd5}) begin
            n_fail++;
            $display("FAIL dir_blocked: got b=%0d h=%0d want 2 5", bus.p2_block, bus.p2_health);
        end
        repeat (2) begin
            bus.p1_state = 4'd7; tick();
            bus.p1_state = 4'd0; tick();
        end
        bus.p1_state = 4'd7; tick();
        bus.p1_state = 4'd0; tick();
        n_checks++;
        if ({bus.p2_block, bus.p2_health} !== {3'd0, 3'd3}) begin
            n_fail++;
            $display("FAIL dir_unblocked_empty: got b=%0d h=%0d want 0 3", bus.p2_block, bus.p2_health);
        end
    endtask

    task automatic test_one_per_swing();
        int pulses = 0;
        do_reset();
        bus.p1_state = 4'd4;
        repeat (5) begin
            tick();
            if (bus.p2_hitFlag == 2'b01) pulses++;
        end
        n_checks++;
        if (pulses != 1 || bus.p2_health !== 3'd4) begin
            n_fail++;
            $display("FAIL single_swing: got pulses=%0d h=%0d want 1 4", pulses, bus.p2_health);
        end
        bus.p1_state = 4'd0; tick();
        bus.p1_state = 4'd4; tick();
        n_checks++;
        if (bus.p2_hitFlag !== 2'b01) begin
            n_fail++;
            $display("FAIL reswing_flag: got %b want 01", bus.p2_hitFlag);
        end
        bus.p1_state = 4'd0; tick();
        n_checks++;
        if (bus.p2_health !== 3'd3) begin
            n_fail++;
            $display("FAIL reswing_damage: got %0d want 3", bus.p2_health);
        end
    endtask

    task automatic test_immunity();
        do_reset();
        bus.p2_state = 4'd9; bus.p1_state = 4'd4; tick();
        bus.p1_state = 4'd0; tick();
        bus.p2_state = 4'd10; bus.p1_state = 4'd7; tick();
        n_checks++;
        if (bus.p2_hitFlag !== 2'b00) begin
            n_fail++;
            $display("FAIL stun_immunity_flag: got %b want 00", bus.p2_hitFlag);
        end
        bus.p1_state = 4'd0; tick();
        n_checks++;
        if ({bus.p2_health, bus.p2_block} !== {3'd5, 3'd3}) begin
            n_fail++;
            $display("FAIL stun_immunity_meter: got h=%0d b=%0d want 5 3", bus.p2_health, bus.p2_block);
        end
    endtask

    task automatic test_trade();
        do_reset();
        set_box(1, 0, 5, 15, 5, 15);
        bus.p1_state = 4'd4; bus.p2_state = 4'd4;
        tick();
        n_checks++;
        if ({bus.p1_hitFlag, bus.p2_hitFlag} !== 4'b0101) begin
            n_fail++;
            $display("FAIL trade_flags: got %b/%b want 01/01", bus.p1_hitFlag, bus.p2_hitFlag);
        end
        bus.p1_state = 4'd0; bus.p2_state = 4'd0;
        tick();
        n_checks++;
        if ({bus.p1_health, bus.p2_health} !== {3'd4, 3'd4}) begin
            n_fail++;
            $display("FAIL trade_damage: got %0d/%0d want 4/4", bus.p1_health, bus.p2_health);
        end
    endtask

    task automatic test_ko();
        int kinds [3] = '{7, 7, 4};
        int bad = 0;
        do_reset();
        bus.p2_state = 4'd2;
        bus.p1_state = 4'd7; tick();
        bus.p1_state = 4'd0; tick();
        bus.p2_state = 4'd0;
        foreach (kinds[i]) begin
            bus.p1_state = 4'(kinds[i]); tick();
            bus.p1_state = 4'd0; tick();
        end
        n_checks++;
        if ({bus.p2_health, bus.ko, bus.p2_block} !== {3'd0, 2'b10, 3'd2}) begin
            n_fail++;
            $display("FAIL ko_set: got h=%0d ko=%b b=%0d want 0 10 2", bus.p2_health, bus.ko, bus.p2_block);
        end
        for (int i = 0; i < 70; i++) begin
            bus.p1_state = (i % 2 == 0) ? 4'd4 : 4'd0;
            tick();
            if (bus.p2_hitFlag !== 2'b00) bad++;
        end
        n_checks++;
        if (bad != 0 || bus.p2_block !== 3'd2 || bus.ko !== 2'b10) begin
            n_fail++;
            $display("FAIL ko_frozen: got flags=%0d b=%0d ko=%b want 0 2 10", bad, bus.p2_block, bus.ko);
        end
        bus.gamestate = 3'd0;
        tick();
        n_checks++;
        if ({bus.p2_health, bus.p2_block, bus.ko} !== {3'd5, 3'd3, 2'b00}) begin
            n_fail++;
            $display("FAIL leave_fight: got h=%0d b=%0d ko=%b want 5 3 00", bus.p2_health, bus.p2_block, bus.ko);
        end
        bus.gamestate = 3'd2;
    endtask

    task automatic test_regen();
        do_reset();
        bus.p2_state = 4'd2;
        repeat (2) begin
            bus.p1_state = 4'd4; tick();
            bus.p1_state = 4'd0; tick();
        end
        n_checks++;
        if (bus.p2_block !== 3'd1) begin
            n_fail++;
            $display("FAIL drain_block: got %0d want 1", bus.p2_block);
        end
        bus.p2_state = 4'd0;
        repeat (T_REGEN) tick();
        n_checks++;
        if ({bus.p2_block, bus.p1_block, bus.p2_health} !== {3'd2, 3'd3, 3'd5}) begin
            n_fail++;
            $display("FAIL regen: got b2=%0d b1=%0d h2=%0d want 2 3 5", bus.p2_block, bus.p1_block, bus.p2_health);
        end
    endtask

    task automatic test_reset_mid_hit();
        do_reset();
        bus.p1_state = 4'd4; tick();
        rst = 1'b0; tick();
        rst = 1'b1; bus.p1_state = 4'd0; tick();
        n_checks++;
        if ({bus.p2_hitFlag, bus.p2_health} !== {2'b00, 3'd5}) begin
            n_fail++;
            $display("FAIL reset_discard: got f=%b h=%0d want 00 5", bus.p2_hitFlag, bus.p2_health);
        end
    endtask

    task automatic rand_box(int p, int kind);
        int x1, y1;
        x1 = $urandom_range(0, 60);
        y1 = $urandom_range(0, 60);
        set_box(p, kind, x1, x1 + $urandom_range(0, 20) - 2, y1, y1 + $urandom_range(0, 20) - 2);
    endtask

    task automatic test_random();
        int choices [10] = '{0, 1, 2, 2, 4, 4, 7, 7, 9, 10};
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            bus.gamestate = ($urandom_range(0, 149) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            if ($urandom_range(0, 2) == 0) bus.p1_state = 4'(choices[$urandom_range(0, 9)]);
            if ($urandom_range(0, 2) == 0) bus.p2_state = 4'(choices[$urandom_range(0, 9)]);
            if ($urandom_range(0, 3) == 0) begin
                for (int p = 0; p < 2; p++)
                    for (int k = 0; k < 3; k++) rand_box(p, k);
            end
            tick();
            n_checks++;
            if ({bus.p1_hitFlag, bus.p2_hitFlag} !== {2'(m_flag[0]), 2'(m_flag[1])}) begin
                n_fail++;
                $display("FAIL rand_flags c%0d: got %b/%b want %0d/%0d", c, bus.p1_hitFlag, bus.p2_hitFlag, m_flag[0], m_flag[1]);
            end
            n_checks++;
            if ({bus.p1_health, bus.p2_health} !== {3'(m_health[0]), 3'(m_health[1])}) begin
                n_fail++;
                $display("FAIL rand_health c%0d: got %0d/%0d want %0d/%0d", c, bus.p1_health, bus.p2_health, m_health[0], m_health[1]);
            end
            n_checks++;
            if ({bus.p1_block, bus.p2_block} !== {3'(m_block[0]), 3'(m_block[1])}) begin
                n_fail++;
                $display("FAIL rand_block c%0d: got %0d/%0d want %0d/%0d", c, bus.p1_block, bus.p2_block, m_block[0], m_block[1]);
            end
            n_checks++;
            if (bus.ko !== {m_ko[1], m_ko[0]}) begin
                n_fail++;
                $display("FAIL rand_ko c%0d: got %b want %b%b", c, bus.ko, m_ko[1], m_ko[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_boundary();
        test_dir_block();
        test_one_per_swing();
        test_immunity();
        test_trade();
        test_ko();
        test_regen();
        test_reset_mid_hit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
